// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALUOp codes, select encodings and FSM state shared by the CPU control blocks
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [2:0] ALUOP_RTYPE = 3'd0;
  localparam logic [2:0] ALUOP_ADD   = 3'd1;
  localparam logic [2:0] ALUOP_SLT   = 3'd2;
  localparam logic [2:0] ALUOP_SUB   = 3'd3;
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ILLEGAL  = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic state_t decode_next(input logic [5:0] op);
    return (op == OP_RTYPE || op == OP_ADDI || op == OP_SLTI) ? EXEC :
           (op == OP_LW || op == OP_SW) ? MEM_ADDR :
           (op == OP_BEQ) ? BRANCH :
           (op == OP_J) ? JUMP : ILLEGAL;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// multicycle_ctrl_outdec: state/opcode to control-vector decode; only pc_write/ir_write see mem_ready/zero
module multicycle_ctrl_outdec
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op = ALUOP_ADD;
        ctrl.pc_src = PC_SRC_ALU;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op = ALUOP_ADD;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op = ALUOP_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = op == OP_RTYPE ? SRCB_RT : SRCB_IMM;
        ctrl.alu_op = op == OP_RTYPE ? ALUOP_RTYPE : op == OP_SLTI ? ALUOP_SLT : ALUOP_ADD;
      end
      ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst = op == OP_RTYPE;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op = ALUOP_SUB;
        ctrl.pc_src = PC_SRC_ALUOUT;
        ctrl.pc_write = zero;
      end
      JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src = PC_SRC_JUMP;
      end
      ILLEGAL: ctrl.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle CPU control FSM; define PERF_CNT_EN to add cycle/instruction counters
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int STATE_W = 4
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [5:0]         instr_op_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic [1:0]         pc_src_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [2:0]         ALUOp_o,
  output logic               illegal_o,
  output logic [STATE_W-1:0] state_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [CNT_W-1:0]   instr_cnt_o
`endif
);
  state_t state;
  ctrl_t  dec, ctrl;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= FETCH;
    else
      case (state)
        FETCH:    if (mem_ready_i) state <= DECODE;
        DECODE:   state <= decode_next(instr_op_i);
        MEM_ADDR: state <= instr_op_i == OP_SW ? MEM_WR : MEM_RD;
        MEM_RD:   if (mem_ready_i) state <= MEM_WB;
        MEM_WR:   if (mem_ready_i) state <= FETCH;
        EXEC:     state <= ALU_WB;
        default:  state <= FETCH;
      endcase
  end

  multicycle_ctrl_outdec u_outdec (
    .state     (state),
    .op        (instr_op_i),
    .mem_ready (mem_ready_i),
    .zero      (zero_i),
    .ctrl      (dec)
  );

  // reset suppresses every strobe in the very cycle it is asserted, even mid-instruction
  assign ctrl = rst_i ? '0 : dec;

  assign pc_write_o   = ctrl.pc_write;
  assign pc_src_o     = ctrl.pc_src;
  assign iord_o       = ctrl.iord;
  assign mem_read_o   = ctrl.mem_read;
  assign mem_write_o  = ctrl.mem_write;
  assign ir_write_o   = ctrl.ir_write;
  assign reg_write_o  = ctrl.reg_write;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign ALUOp_o      = ctrl.alu_op;
  assign illegal_o    = ctrl.illegal;
  assign state_o      = rst_i ? '0 : STATE_W'(state);

`ifdef PERF_CNT_EN
  logic retire;
  assign retire = (state inside {MEM_WB, ALU_WB, BRANCH, JUMP, ILLEGAL}) || (state == MEM_WR && mem_ready_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_o <= '0;
      instr_cnt_o <= '0;
    end else begin
      cycle_cnt_o <= cycle_cnt_o + 1'b1;
      instr_cnt_o <= instr_cnt_o + CNT_W'(retire);
    end
  end
`endif
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle CPU datapath.
- Sits directly upstream of the ALU controller.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath strobes, mux selects and the 3-bit ALUOp code that the ALU controller consumes alongside funct.

Parameters:
- STATE_W, 4, width of state register / state_o.
- CNT_W, 32, width of performance counters (used only with PERF_CNT_EN).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- instr_op_i  in  6  opcode field of the instruction register.
- zero_i  in  1  ALU zero flag (used for beq).
- mem_ready_i  in  1  memory handshake; the access completes in a cycle where this is 1.
- pc_write_o  out  1  PC load enable.
- pc_src_o  out  2  PC source: 0 = ALU result, 1 = ALUOut register, 2 = jump target.
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- ir_write_o  out  1  instruction register load.
- reg_write_o  out  1  register file write enable.
- reg_dst_o  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg_o  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- alu_src_a_o  out  1  ALU A input: 0 = PC, 1 = rs.
- alu_src_b_o  out  2  ALU B input: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2.
- ALUOp_o  out  3  0 = R-type, 1 = add, 2 = slt, 3 = sub.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk_i, rst_i).
  - While rst_i = 1, state is forced to FETCH on each edge.
  - All write and request strobes are forced to 0: pc_write, ir_write, reg_write, mem_read, mem_write, illegal.
  - All selects are 0 and state_o = 0.
- Output timing: outputs are a Moore decode of the registered state. The only exceptions are pc_write_o and ir_write_o, which are gated by mem_ready_i / zero_i as listed below.
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, ILLEGAL=10. Codes 11–15 are unreachable and return to FETCH on the next edge with all strobes 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, ALUOp=1, pc_src=0.
  - ir_write = pc_write = mem_ready_i.
  - Stays in FETCH while mem_ready_i = 0; goes to DECODE when it is 1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, ALUOp=1 (branch target into ALUOut).
  - Next state by opcode:
    - 0 (R-type) → EXEC
    - 8 (addi) → EXEC
    - 10 (slti) → EXEC
    - 35 (lw) → MEM_ADDR
    - 43 (sw) → MEM_ADDR
    - 4 (beq) → BRANCH
    - 2 (j) → JUMP
    - anything else → ILLEGAL
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=2, ALUOp=1.
  - Goes to MEM_RD for lw, MEM_WR for sw.
  - The opcode is resampled from the instruction register, which is stable after FETCH.
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready_i, then → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, then → FETCH.
- MEM_WR: mem_write=1, iord=1. Waits for mem_ready_i, then → FETCH.
- EXEC:
  - Common outputs: alu_src_a=1.
  - R-type: alu_src_b=0, ALUOp=0.
  - addi: alu_src_b=2, ALUOp=1.
  - slti: alu_src_b=2, ALUOp=2.
  - Then → ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst = (opcode == 0), then → FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, ALUOp=3, pc_src=1.
  - pc_write = zero_i.
  - Then → FETCH.
- JUMP: pc_write=1, pc_src=2, then → FETCH.
- ILLEGAL: illegal_o=1 for exactly one cycle, no writes, then → FETCH. The PC has already advanced by 4.
- Cycle counts with mem_ready_i held at 1: lw 5, sw 4, R-type/addi/slti 4, beq 3, j 3.
- Boundary conditions:
  - mem_ready_i = 1 in the first cycle of a wait state means no stall.
  - rst_i asserted mid-instruction aborts it; no strobe fires in that cycle.

Optional Feature:
- Macro: PERF_CNT_EN.
- When defined, two extra outputs are added:
  - cycle_cnt_o [CNT_W]: +1 every non-reset cycle.
  - instr_cnt_o [CNT_W]: +1 on every transition into FETCH from MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP or ILLEGAL.
- Both counters are cleared to 0 by rst_i and wrap modulo 2^CNT_W.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package (cpu_pkg) holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SLTI, OP_BEQ, OP_LW, OP_SW, OP_J;
  - ALUOp codes: ALUOP_RTYPE=0, ALUOP_ADD=1, ALUOP_SLT=2, ALUOP_SUB=3. These are shared with the ALU controller.
  - the state enum;
  - the alu_src_b and pc_src select encodings.
- Natural sub-module: multicycle_ctrl_outdec, a pure state/opcode → control-vector decoder. The FSM stays in the top module.

Test Plan:
- Reset then lw (opcode 35), mem_ready_i = 1 → states 0, 1, 2, 3, 4, 0. reg_write=1 and mem_to_reg=1 only in state 4.
- lw with mem_ready_i low for 3 cycles in MEM_RD → stays in state 3 for 4 cycles, then 4. No reg_write while stalled.
- R-type (op 0) → DECODE then EXEC with ALUOp=0, alu_src_b=0, then ALU_WB with reg_dst=1.
- slti (op 10) → EXEC with ALUOp=2, alu_src_b=2.
- beq:
  - zero_i=1 in BRANCH → pc_write=1, pc_src=1, ALUOp=3.
  - zero_i=0 → pc_write=0.
  - Both cases: 3 cycles total.
- Opcode 63 → ILLEGAL with illegal_o=1 for one cycle, no writes, then FETCH.
- rst_i asserted during MEM_WR → next state FETCH, mem_write=0 in that cycle.
- With PERF_CNT_EN, after 5 instructions → instr_cnt_o=5 and cycle_cnt_o equals the sum of their state counts.
